// File: rtl/cmd_framer_pkg.sv
// Shared types and helpers for the command framer: TX state encoding and
// byte selection within a word honouring the configured wire byte order.
package cmd_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } tx_state_t;

    // Widest word the helper handles (8 bytes).
    localparam int MAX_BYTES = 8;

    // Return the byte that travels at wire position idx of an nbytes-wide word.
    // With msb_first the first wire byte is the most significant one.
    function automatic logic [7:0] byte_sel(input logic [63:0] word,
                                            input int          idx,
                                            input logic        msb_first,
                                            input int          nbytes);
        int pos;
        if (msb_first) begin
            pos = nbytes - 32'sd1 - idx;
        end else begin
            pos = idx;
        end
        return 8'(word >> (pos * 32'sd8));
    endfunction

endpackage

// File: rtl/cmd_framer_tx.sv
// Response serialiser: latches the response word and hands it byte by byte
// to the UART transmitter, pacing on tx_done.
module cmd_framer_tx
    import cmd_framer_pkg::*;
#(
    parameter int RESP_BYTES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    snd_resp,
    input  logic                    tx_done,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    output logic                    resp_snt
);

    localparam int IW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;

    tx_state_t               state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [8*RESP_BYTES-1:0] resp_q, resp_d;
    logic                    wait2_q, wait2_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    trmt_q, trmt_d;
    logic                    resp_snt_q, resp_snt_d;

    // Next-state logic; trmt/resp_snt are computed for the state being entered
    // so the registered pulses line up with LOAD and DONE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        resp_d     = resp_q;
        wait2_d    = wait2_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        resp_snt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (snd_resp) begin
                    resp_d    = resp;
                    idx_d     = '0;
                    state_d   = LOAD;
                    trmt_d    = 1'b1;
                    tx_data_d = byte_sel(64'(resp), 32'sd0, (MSB_FIRST != 0), RESP_BYTES);
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = WAIT;
                wait2_d = 1'b0;
            end
            WAIT: begin
                // The transmitter may still report the previous byte as done
                // in the clk right after trmt, so that clk is skipped.
                if (!wait2_q) begin
                    wait2_d = 1'b1;
                end else if (tx_done) begin
                    if (idx_q == IW'(RESP_BYTES - 1)) begin
                        state_d    = DONE;
                        resp_snt_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        state_d   = LOAD;
                        trmt_d    = 1'b1;
                        tx_data_d = byte_sel(64'(resp_q), int'(idx_q) + 32'sd1,
                                             (MSB_FIRST != 0), RESP_BYTES);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            resp_q     <= '0;
            wait2_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            trmt_q     <= 1'b0;
            resp_snt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            resp_q     <= resp_d;
            wait2_q    <= wait2_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
            resp_snt_q <= resp_snt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign trmt     = trmt_q;
    assign resp_snt = resp_snt_q;

endmodule

// File: rtl/cmd_framer.sv
// UART command framer: assembles CMD_BYTES received bytes into a command with
// double buffering, overrun and inter-byte timeout handling, and serialises
// responses through cmd_framer_tx.
module cmd_framer
    import cmd_framer_pkg::*;
#(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 65535,
    parameter int MSB_FIRST   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    output logic                    overrun,
    output logic                    timeout_err,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    snd_resp,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    input  logic                    tx_done,
    output logic                    resp_snt
);

    localparam int CMDW = 8 * CMD_BYTES;
    localparam int IW   = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int CW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // shadow_q holds bytes in arrival order: wire byte i at bits [8i+7:8i].
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CMDW-1:0] shadow_q, shadow_d;
    logic [CMDW-1:0] cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            overrun_q, overrun_d;
    logic            timeout_err_q, timeout_err_d;
    logic [CMDW-1:0] arrive_s;
    logic [CMDW-1:0] word_s;
    logic            last_s;

    assign clr_rx_rdy = rx_rdy;

    // Frame assembly: insert the incoming byte, reorder into the command word,
    // handle completion/overrun, consumer acknowledge and inter-byte timeout.
    always_comb begin
        arrive_s = shadow_q;
        for (int i = 0; i < CMD_BYTES; i++) begin
            if (idx_q == IW'(i)) begin
                arrive_s[8*i +: 8] = rx_data;
            end else begin
                arrive_s[8*i +: 8] = shadow_q[8*i +: 8];
            end
        end
        word_s = '0;
        for (int k = 0; k < CMD_BYTES; k++) begin
            word_s[8*k +: 8] = byte_sel(64'(arrive_s), k, (MSB_FIRST != 0), CMD_BYTES);
        end
        last_s = rx_rdy && (idx_q == IW'(CMD_BYTES - 1));

        idx_d         = idx_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        cmd_d         = cmd_q;
        cmd_rdy_d     = cmd_rdy_q;
        overrun_d     = overrun_q;
        timeout_err_d = 1'b0;

        if (rx_rdy) begin
            cnt_d = '0;
            if (last_s) begin
                idx_d    = '0;
                shadow_d = '0;
            end else begin
                idx_d    = idx_q + IW'(1);
                shadow_d = arrive_s;
            end
        end else if ((idx_q != '0) && (TIMEOUT_CYC != 0)) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                idx_d         = '0;
                shadow_d      = '0;
                cnt_d         = '0;
                timeout_err_d = 1'b1;
            end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end

        // Completion beats a same-clk acknowledge; the consumer's ack also
        // clears the sticky overrun.
        if (last_s) begin
            if (!cmd_rdy_q || clr_cmd_rdy) begin
                cmd_d     = word_s;
                cmd_rdy_d = 1'b1;
                if (clr_cmd_rdy) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
            overrun_d = 1'b0;
        end else begin
            cmd_rdy_d = cmd_rdy_q;
        end
    end

    // RX state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            cmd_q         <= '0;
            cmd_rdy_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            cmd_q         <= cmd_d;
            cmd_rdy_q     <= cmd_rdy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

    cmd_framer_tx #(
        .RESP_BYTES (RESP_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .resp     (resp),
        .snd_resp (snd_resp),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .trmt     (trmt),
        .resp_snt (resp_snt)
    );

endmodule

// File: tb/tb_cmd_framer.sv
// Directed bench for cmd_framer: two instances (MS byte first and LS byte
// first) share all stimulus; a small UART transmitter model answers trmt.
module tb_cmd_framer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] resp;
    logic        snd_resp;
    logic        tx_done;

    logic        clr_rx_rdy,  clr_rx_rdy_l;
    logic [23:0] cmd,         cmd_l;
    logic        cmd_rdy,     cmd_rdy_l;
    logic        overrun,     overrun_l;
    logic        timeout_err, timeout_err_l;
    logic [7:0]  tx_data,     tx_data_l;
    logic        trmt,        trmt_l;
    logic        resp_snt,    resp_snt_l;

    int checks   = 0;
    int failures = 0;

    // UART model bookkeeping
    int         cyc = 0;
    int         dly = 0;
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];
    int         trmt_cyc[$];
    int         snt_cyc[$];

    cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYC(20), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun), .timeout_err(timeout_err),
        .resp(resp), .snd_resp(snd_resp), .tx_data(tx_data), .trmt(trmt),
        .tx_done(tx_done), .resp_snt(resp_snt)
    );

    cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYC(20), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy_l), .cmd(cmd_l), .cmd_rdy(cmd_rdy_l),
        .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun_l), .timeout_err(timeout_err_l),
        .resp(resp), .snd_resp(snd_resp), .tx_data(tx_data_l), .trmt(trmt_l),
        .tx_done(tx_done), .resp_snt(resp_snt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART transmitter model: tx_done drops on trmt and rises 3 clks later.
    initial begin
        tx_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (trmt) begin
                cap0.push_back(tx_data);
                cap1.push_back(tx_data_l);
                trmt_cyc.push_back(cyc);
                tx_done = 1'b0;
                dly = 3;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) tx_done = 1'b1;
            end
            if (resp_snt) snt_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        rx_data     = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = with_clr;
        step();
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cmd !== 24'h0) begin failures++; $display("FAIL reset_cmd got=%h exp=000000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (trmt !== 1'b0 || resp_snt !== 1'b0) begin failures++; $display("FAIL reset_tx_pulses got=%b%b exp=00", trmt, resp_snt); end
        checks++; if (clr_rx_rdy !== 1'b0) begin failures++; $display("FAIL reset_clr_rx_rdy got=%b exp=0", clr_rx_rdy); end
    endtask

    task automatic test_basic();
        send_byte(8'hAB, 1'b0);
        rx_data = 8'hCD; rx_rdy = 1'b1;
        #1;
        checks++; if (clr_rx_rdy !== 1'b1) begin failures++; $display("FAIL clr_rx_rdy got=%b exp=1", clr_rx_rdy); end
        step();
        rx_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_early_rdy got=%b exp=0", cmd_rdy); end
        send_byte(8'hEF, 1'b0);
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL basic_rdy got=%b exp=1", cmd_rdy); end
        checks++; if (cmd !== 24'hABCDEF) begin failures++; $display("FAIL basic_cmd got=%h exp=abcdef", cmd); end
        checks++; if (cmd_l !== 24'hEFCDAB) begin failures++; $display("FAIL basic_cmd_lsb got=%h exp=efcdab", cmd_l); end
        pulse_clr();
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_clr got=%b exp=0", cmd_rdy); end
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        checks++; if (cmd !== 24'h123456 || cmd_rdy !== 1'b1) begin failures++; $display("FAIL basic_cmd2 got=%h/%b exp=123456/1", cmd, cmd_rdy); end
        checks++; if (cmd_l !== 24'h563412) begin failures++; $display("FAIL basic_cmd2_lsb got=%h exp=563412", cmd_l); end
        pulse_clr();
    endtask

    task automatic test_overrun();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun); end
        send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
        checks++; if (cmd !== 24'h112233) begin failures++; $display("FAIL ovr_cmd got=%h exp=112233", cmd); end
        checks++; if (cmd_l !== 24'h332211) begin failures++; $display("FAIL ovr_cmd_lsb got=%h exp=332211", cmd_l); end
        checks++; if (overrun !== 1'b1 || cmd_rdy !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b/%b exp=1/1", overrun, cmd_rdy); end
        pulse_clr();
        checks++; if (overrun !== 1'b0 || cmd_rdy !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b/%b exp=0/0", overrun, cmd_rdy); end
    endtask

    task automatic test_same_clk();
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b1);
        checks++; if (cmd !== 24'h778899) begin failures++; $display("FAIL same_cmd got=%h exp=778899", cmd); end
        checks++; if (cmd_l !== 24'h998877) begin failures++; $display("FAIL same_cmd_lsb got=%h exp=998877", cmd_l); end
        checks++; if (cmd_rdy !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL same_flags got=%b/%b exp=1/0", cmd_rdy, overrun); end
        pulse_clr();
    endtask

    task automatic test_timeout();
        send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (timeout_err !== (i == 20)) begin failures++; $display("FAIL to_pulse idle=%0d got=%b exp=%b", i, timeout_err, (i == 20)); end
        end
        step();
        checks++; if (timeout_err !== 1'b0 || cmd_rdy !== 1'b0) begin failures++; $display("FAIL to_after got=%b/%b exp=0/0", timeout_err, cmd_rdy); end
        send_byte(8'hC3, 1'b0); send_byte(8'hD4, 1'b0); send_byte(8'hE5, 1'b0);
        checks++; if (cmd !== 24'hC3D4E5 || cmd_rdy !== 1'b1) begin failures++; $display("FAIL to_resync got=%h/%b exp=c3d4e5/1", cmd, cmd_rdy); end
        pulse_clr();
        send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            step();
            checks++;
            if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_edge_idle idle=%0d got=%b exp=0", i, timeout_err); end
        end
        send_byte(8'hC3, 1'b0);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_edge_byte got=%b exp=0", timeout_err); end
        checks++; if (cmd !== 24'hA1B2C3 || cmd_rdy !== 1'b1) begin failures++; $display("FAIL to_edge_cmd got=%h/%b exp=a1b2c3/1", cmd, cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_tx();
        int n0;
        int s0;
        int extra;
        n0 = cap0.size();
        s0 = snt_cyc.size();
        extra = 0;
        resp = 16'hA55A; snd_resp = 1'b1;
        step();
        snd_resp = 1'b0; resp = 16'h1234;
        for (int i = 0; i < 24; i++) begin
            snd_resp = (i == 2) ? 1'b1 : 1'b0;
            step();
            if (resp_snt) begin
                snd_resp = 1'b1;
                step();
                snd_resp = 1'b0;
                i = i + 1;
            end
        end
        snd_resp = 1'b0;
        step();
        checks++; if (cap0.size() - n0 !== 2) begin failures++; $display("FAIL tx_count got=%0d exp=2", cap0.size() - n0); end
        if (cap0.size() - n0 >= 2) begin
            checks++; if (cap0[n0] !== 8'hA5 || cap0[n0+1] !== 8'h5A) begin failures++; $display("FAIL tx_bytes got=%h,%h exp=a5,5a", cap0[n0], cap0[n0+1]); end
            checks++; if (cap1[n0] !== 8'h5A || cap1[n0+1] !== 8'hA5) begin failures++; $display("FAIL tx_bytes_lsb got=%h,%h exp=5a,a5", cap1[n0], cap1[n0+1]); end
            checks++; if (trmt_cyc[n0+1] - trmt_cyc[n0] !== 4) begin failures++; $display("FAIL tx_pace got=%0d exp=4", trmt_cyc[n0+1] - trmt_cyc[n0]); end
            if (snt_cyc.size() > s0) extra = snt_cyc[s0] - trmt_cyc[n0+1];
            checks++; if (extra !== 4) begin failures++; $display("FAIL tx_snt_delay got=%0d exp=4", extra); end
        end
        checks++; if (snt_cyc.size() - s0 !== 1) begin failures++; $display("FAIL tx_snt_count got=%0d exp=1", snt_cyc.size() - s0); end
    endtask

    task automatic test_reset_mid();
        int n1;
        int s1;
        send_byte(8'h21, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h23, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        resp = 16'hBEEF; snd_resp = 1'b1;
        step();
        snd_resp = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++; if (cmd !== 24'h0 || cmd_rdy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rmid_rx got=%h/%b/%b exp=000000/0/0", cmd, cmd_rdy, overrun); end
        checks++; if (tx_data !== 8'h00 || trmt !== 1'b0 || resp_snt !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rmid_tx got=%h/%b/%b/%b exp=00/0/0/0", tx_data, trmt, resp_snt, timeout_err); end
        rst_n = 1'b1;
        n1 = cap0.size();
        s1 = snt_cyc.size();
        repeat (12) step();
        checks++; if (cap0.size() !== n1 || snt_cyc.size() !== s1) begin failures++; $display("FAIL rmid_no_tx got=%0d/%0d exp=%0d/%0d", cap0.size(), snt_cyc.size(), n1, s1); end
        send_byte(8'h5A, 1'b0); send_byte(8'h6B, 1'b0);
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL rmid_idx got=%b exp=0", cmd_rdy); end
        send_byte(8'h7C, 1'b0);
        checks++; if (cmd !== 24'h5A6B7C || cmd_rdy !== 1'b1) begin failures++; $display("FAIL rmid_frame got=%h/%b exp=5a6b7c/1", cmd, cmd_rdy); end
        checks++; if (cmd_l !== 24'h7C6B5A) begin failures++; $display("FAIL rmid_frame_lsb got=%h exp=7c6b5a", cmd_l); end
        pulse_clr();
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        resp = 16'h0000; snd_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_overrun();
        test_same_clk();
        test_timeout();
        test_tx();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
